// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with start/pause, lap snapshot and clear.
// Two debounced pushbuttons and a same-domain 1 Hz level edge-detected as data.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], key_n};
      level_d <= level;
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Single-cycle pulse on the debounced falling edge only.
  assign press = level_d & ~level;
endmodule

module stopwatch_core #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       key_start_stop_n,
  input  logic       key_lap_clear_n,
  output logic [3:0] digit_min_tens,
  output logic [3:0] digit_min_ones,
  output logic [3:0] digit_sec_tens,
  output logic [3:0] digit_sec_ones,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } mmss_t;

  logic [1:0] keys_n, press;
  assign keys_n = {key_lap_clear_n, key_start_stop_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .key_n     (keys_n[k]),
      .press     (press[k])
    );
  end

  state_t state, state_n;
  mmss_t  live, snap, inc;
  logic   tick_d, tick_rise, wrap;
  logic   lap_on, ovf_sticky;
  logic   ss, lc, do_cap, do_unlap, do_clear, count_en;

  assign tick_rise = tick_in & ~tick_d;
  assign ss        = press[0];
  assign lc        = press[1] & ~press[0];
  assign count_en  = tick_rise && (state == RUN);

  always_comb begin
    inc  = live;
    wrap = 1'b0;
    if (live.so != 4'd9) inc.so = live.so + 4'd1;
    else begin
      inc.so = 4'd0;
      if (live.st != 4'd5) inc.st = live.st + 4'd1;
      else begin
        inc.st = 4'd0;
        if (live.mo != 4'd9) inc.mo = live.mo + 4'd1;
        else begin
          inc.mo = 4'd0;
          if (live.mt != 4'd5) inc.mt = live.mt + 4'd1;
          else begin
            inc.mt = 4'd0;
            wrap   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_cap   = 1'b0;
    do_unlap = 1'b0;
    do_clear = 1'b0;
    case (state)
      IDLE:  if (ss) state_n = RUN;
      RUN: begin
        if (ss) state_n = PAUSE;
        else if (lc) begin
          if (lap_on) do_unlap = 1'b1;
          else        do_cap   = 1'b1;
        end
      end
      PAUSE: begin
        if (ss) state_n = RUN;
        else if (lc) begin
          state_n  = IDLE;
          do_clear = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Snapshot captures live before this cycle's increment lands.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      tick_d     <= 1'b0;
      live       <= '0;
      snap       <= '0;
      lap_on     <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      tick_d <= tick_in;
      if (do_clear) begin
        live       <= '0;
        snap       <= '0;
        lap_on     <= 1'b0;
        ovf_sticky <= 1'b0;
      end else begin
        if (count_en) begin
          live <= inc;
          if (wrap) ovf_sticky <= 1'b1;
        end
        if (do_cap) begin
          snap   <= live;
          lap_on <= 1'b1;
        end
        if (do_unlap) lap_on <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      {digit_min_tens, digit_min_ones, digit_sec_tens, digit_sec_ones} <= '0;
      running  <= 1'b0;
      lap_hold <= 1'b0;
      overflow <= 1'b0;
    end else begin
      {digit_min_tens, digit_min_ones, digit_sec_tens, digit_sec_ones} <= lap_on ? snap : live;
      running  <= (state == RUN);
      lap_hold <= lap_on;
      overflow <= ovf_sticky;
    end
  end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Consumes the 1 Hz toggle output of the clock divider and the two DE10-Lite pushbuttons. Runs a start/pause/lap/clear stopwatch counting MM:SS in BCD, from 00:00 to 59:59. Feeds four BCD digits plus status flags to the downstream 7-segment multiplexer. Single clock domain; the 1 Hz input is treated as data and edge-detected, never used as a clock.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable clk_50MHz cycles (20 ms) needed to accept a key level change; the bench uses 4.

Ports:
clk_50MHz  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous, active-low reset
tick_in  input  1  clk_1Hz level from the clock divider; each rising edge is one second
key_start_stop_n  input  1  raw pushbutton, active-low, asynchronous
key_lap_clear_n  input  1  raw pushbutton, active-low, asynchronous
digit_min_tens  output  4  BCD 0-5
digit_min_ones  output  4  BCD 0-9
digit_sec_tens  output  4  BCD 0-5
digit_sec_ones  output  4  BCD 0-9
running  output  1  high in RUN state
lap_hold  output  1  high while the displayed digits are a frozen lap snapshot
overflow  output  1  sticky; set on wrap from 59:59 to 00:00

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; live count, lap snapshot and all digit outputs 0.
  - running = 0, lap_hold = 0, overflow = 0.
  - Key synchronisers and debounced levels reset to 1 (released); debounce counters 0; tick_d = 0.
  - Reset mid-operation aborts everything immediately. After release no press or tick event may fire unless a genuine new edge occurs.
- Key path, per key:
  - 2-FF synchroniser, then debouncer.
  - Debouncer: a counter increments while the synced level differs from the debounced level and clears otherwise. When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - The press pulse is high for exactly 1 cycle, the cycle after the debounced level goes 1 to 0.
  - Release generates no event. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Tick detect:
  - tick_d <= tick_in; tick_rise = tick_in & ~tick_d.
  - tick_in comes from the same clock domain, so it has no synchroniser.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop press -> RUN.
  - RUN + start_stop press -> PAUSE.
  - PAUSE + start_stop press -> RUN.
  - RUN + lap_clear press:
    - if lap_hold = 0: copy the live count into the snapshot and set lap_hold = 1.
    - if lap_hold = 1: clear lap_hold to 0.
  - PAUSE + lap_clear press -> IDLE. Live count, snapshot and overflow go to 0; lap_hold = 0.
  - IDLE + lap_clear press: no effect.
  - Both press pulses in the same cycle: start_stop is acted on and lap_clear is dropped.
- Counting:
  - Happens only on a cycle where tick_rise = 1 and the registered state is RUN.
  - Cascaded BCD increment: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0 wraps.
  - At 59:59 a tick gives 00:00 and sets overflow. Counting continues after the wrap.
  - The digits never hold non-BCD values.
- Latency: the count becomes visible on the outputs 1 cycle after the tick_rise cycle, i.e. 2 clocks after tick_in rises.
- Simultaneous events:
  - Tick and RUN->PAUSE press in the same cycle: the tick is counted.
  - Tick and PAUSE->RUN press in the same cycle: the tick is not counted.
  - Tick and lap capture in the same cycle: the snapshot takes the pre-increment value.
- Outputs:
  - Digits show the snapshot when lap_hold = 1, otherwise the live count.
  - All outputs are registered.
  - RUN->PAUSE keeps lap_hold unchanged, so the frozen lap stays visible.
  - Sub-second phase is not reset on start; the first second after start may be short. This is accepted.

Test Plan:
- Release reset with keys released and tick_in toggling -> digits 00:00, running = 0, state stays IDLE for 10 ticks.
- Press start (held 10 cycles, DEBOUNCE_CYCLES = 4), then 75 tick rises -> digits 01:15, running = 1. A 2-cycle key glitch mid-run -> no state change.
- RUN, preload via 3599 ticks -> 59:59; one more tick -> 00:00, overflow = 1. Pause, then lap_clear -> 00:00, overflow = 0, IDLE.
- RUN at 00:07, press lap -> display frozen at 00:07, lap_hold = 1. After 5 ticks display is still 00:07. Press lap -> display 00:12, lap_hold = 0.
- Align a start_stop press pulse with a tick_rise in RUN at 00:20 -> PAUSE with 00:21. Align again from PAUSE -> RUN, still 00:21.
- Assert rst_n low for 1 cycle while running at 03:42 with lap_hold = 1 -> all outputs 0 immediately (asynchronously), state IDLE, no spurious press after release.
